vc_cleaner_rr: RTL and testbench

- Parametrised, sequential successor to the combinational VC cleaner in the NoC-to-AXI4-Lite bridge NoC output path.
- Tracks per-virtual-channel ownership and credits for NUM_VC channels and allocates free VCs round-robin.
- Retires ("cleans") a VC only after its tail flit has been sent and all downstream credits have returned.

---
 rtl/vc_cleaner_rr.sv | 172 +++++++++++++++++
 tb/tb_vc_cleaner_rr.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/vc_cleaner_rr.sv
// vc_cleaner_rr: per-VC ownership and credit tracker for the NoC output path.
// Free VCs are handed out round-robin; a VC is retired only after its tail
// flit has left and every downstream credit for it has come back.
module vc_cleaner_rr #(
    parameter int unsigned NUM_VC  = 7,
    parameter int unsigned CREDITS = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              alloc_req,
    output logic              alloc_gnt,
    output logic [NUM_VC-1:0] alloc_vc,
    input  logic              send_valid,
    input  logic [NUM_VC-1:0] send_vc,
    input  logic              send_tail,
    input  logic              cred_valid,
    input  logic [NUM_VC-1:0] cred_vc,
    output logic [NUM_VC-1:0] vc_busy,
    output logic [NUM_VC-1:0] vc_credit_ok,
    output logic              err
);

    localparam int unsigned CW  = $clog2(CREDITS + 1);
    localparam int unsigned PW  = $clog2(NUM_VC);
    localparam int unsigned PW1 = PW + 1;

    localparam logic [CW-1:0] CntFull = CW'(CREDITS);

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StActive = 2'd1;
    localparam logic [1:0] StDrain  = 2'd2;

    logic [1:0]        rst_sync_q;
    logic              rst_int_n;

    logic [1:0]        st_q  [NUM_VC];
    logic [1:0]        st_d  [NUM_VC];
    logic [CW-1:0]     cnt_q [NUM_VC];
    logic [CW-1:0]     cnt_d [NUM_VC];
    logic [PW-1:0]     rr_q, rr_d;
    logic              gnt_q;
    logic [NUM_VC-1:0] gnt_vc_q;
    logic              err_q, err_d;

    logic              send_oh, cred_oh;
    logic [NUM_VC-1:0] send_hit, cred_hit, send_ok, cred_ok;
    logic              gnt_valid;
    logic [PW-1:0]     gnt_idx;
    logic [NUM_VC-1:0] gnt_oh;
    logic [PW1-1:0]    scan;

    // Reset synchroniser: assertion is immediate, release waits two edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_int_n = rst_sync_q[1];

    // Address decode; a non-one-hot select addresses no VC at all.
    assign send_oh  = $onehot(send_vc);
    assign cred_oh  = $onehot(cred_vc);
    assign send_hit = (send_valid && send_oh) ? send_vc : '0;
    assign cred_hit = (cred_valid && cred_oh) ? cred_vc : '0;

    // Round-robin search for the first idle VC at or after the pointer.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        gnt_oh    = '0;
        scan      = '0;
        rr_d      = rr_q;
        if (alloc_req) begin
            for (int unsigned i = 0; i < NUM_VC; i++) begin
                scan = {1'b0, rr_q} + PW1'(i);
                if (scan >= PW1'(NUM_VC)) begin
                    scan = scan - PW1'(NUM_VC);
                end
                if (!gnt_valid && st_q[scan[PW-1:0]] == StIdle) begin
                    gnt_valid = 1'b1;
                    gnt_idx   = scan[PW-1:0];
                end
            end
        end
        if (gnt_valid) begin
            gnt_oh[gnt_idx] = 1'b1;
            rr_d = (gnt_idx == PW'(NUM_VC - 1)) ? '0 : gnt_idx + PW'(1);
        end
    end

    // Per-VC credit and state update; illegal updates are dropped and flagged.
    always_comb begin
        err_d   = err_q;
        send_ok = '0;
        cred_ok = '0;
        if ((send_valid && !send_oh) || (cred_valid && !cred_oh)) begin
            err_d = 1'b1;
        end
        for (int unsigned i = 0; i < NUM_VC; i++) begin
            send_ok[i] = send_hit[i] && (st_q[i] == StActive) && (cnt_q[i] != '0);
            // A same-cycle legal send makes room for a credit on a full counter.
            cred_ok[i] = cred_hit[i] && ((cnt_q[i] != CntFull) || send_ok[i]);
            if ((send_hit[i] && !send_ok[i]) || (cred_hit[i] && !cred_ok[i])) begin
                err_d = 1'b1;
            end

            cnt_d[i] = cnt_q[i];
            if (send_ok[i] && !cred_ok[i]) begin
                cnt_d[i] = cnt_q[i] - CW'(1);
            end else if (cred_ok[i] && !send_ok[i]) begin
                cnt_d[i] = cnt_q[i] + CW'(1);
            end

            st_d[i] = st_q[i];
            case (st_q[i])
                StIdle: begin
                    if (gnt_oh[i]) st_d[i] = StActive;
                end
                StActive: begin
                    if (send_ok[i] && send_tail) begin
                        st_d[i] = (cnt_d[i] == CntFull) ? StIdle : StDrain;
                    end
                end
                StDrain: begin
                    if (cnt_d[i] == CntFull) st_d[i] = StIdle;
                end
                default: st_d[i] = StIdle;
            endcase
        end
    end

    // State registers; everything is discarded on reset.
    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            for (int unsigned i = 0; i < NUM_VC; i++) begin
                st_q[i]  <= StIdle;
                cnt_q[i] <= CntFull;
            end
            rr_q     <= '0;
            gnt_q    <= 1'b0;
            gnt_vc_q <= '0;
            err_q    <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < NUM_VC; i++) begin
                st_q[i]  <= st_d[i];
                cnt_q[i] <= cnt_d[i];
            end
            rr_q     <= rr_d;
            gnt_q    <= gnt_valid;
            gnt_vc_q <= gnt_oh;
            err_q    <= err_d;
        end
    end

    // Status outputs straight from registered state.
    always_comb begin
        vc_busy      = '0;
        vc_credit_ok = '0;
        for (int unsigned i = 0; i < NUM_VC; i++) begin
            vc_busy[i]      = (st_q[i] != StIdle);
            vc_credit_ok[i] = (st_q[i] == StActive) && (cnt_q[i] != '0);
        end
    end

    assign alloc_gnt = gnt_q;
    assign alloc_vc  = gnt_vc_q;
    assign err       = err_q;

endmodule

// File: tb/tb_vc_cleaner_rr.sv
// Directed bench for vc_cleaner_rr with NUM_VC=7, CREDITS=4.
module tb_vc_cleaner_rr;

    localparam int unsigned N = 7;

    logic         clk;
    logic         rst_n;
    logic         alloc_req;
    logic         alloc_gnt;
    logic [N-1:0] alloc_vc;
    logic         send_valid;
    logic [N-1:0] send_vc;
    logic         send_tail;
    logic         cred_valid;
    logic [N-1:0] cred_vc;
    logic [N-1:0] vc_busy;
    logic [N-1:0] vc_credit_ok;
    logic         err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic         req;
        logic         sv;
        logic [N-1:0] svc;
        logic         tail;
        logic         cv;
        logic [N-1:0] cvc;
        logic         gnt;
        logic [N-1:0] vc;
        logic [N-1:0] busy;
        logic [N-1:0] cok;
        logic         err;
    } vec_t;

    vec_t tbl[$];

    vc_cleaner_rr #(
        .NUM_VC (7),
        .CREDITS(4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .alloc_req   (alloc_req),
        .alloc_gnt   (alloc_gnt),
        .alloc_vc    (alloc_vc),
        .send_valid  (send_valid),
        .send_vc     (send_vc),
        .send_tail   (send_tail),
        .cred_valid  (cred_valid),
        .cred_vc     (cred_vc),
        .vc_busy     (vc_busy),
        .vc_credit_ok(vc_credit_ok),
        .err         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic eg, input logic [N-1:0] ev,
                         input logic [N-1:0] eb, input logic [N-1:0] ec, input logic ee);
        checks++;
        if ({alloc_gnt, alloc_vc, vc_busy, vc_credit_ok, err} !== {eg, ev, eb, ec, ee}) begin
            errors++;
            $display("FAIL %s: got gnt=%b vc=%b busy=%b cok=%b err=%b, want gnt=%b vc=%b busy=%b cok=%b err=%b",
                     name, alloc_gnt, alloc_vc, vc_busy, vc_credit_ok, err, eg, ev, eb, ec, ee);
        end
    endtask

    // Drive one cycle of inputs, sample 1 time unit after the edge, then idle the inputs.
    task automatic cyc(input logic req, input logic sv, input logic [N-1:0] svc,
                       input logic tail, input logic cv, input logic [N-1:0] cvc);
        alloc_req  = req;
        send_valid = sv;
        send_vc    = svc;
        send_tail  = tail;
        cred_valid = cv;
        cred_vc    = cvc;
        @(posedge clk);
        #1;
        alloc_req  = 1'b0;
        send_valid = 1'b0;
        send_vc    = '0;
        send_tail  = 1'b0;
        cred_valid = 1'b0;
        cred_vc    = '0;
    endtask

    task automatic release_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic full_reset();
        rst_n = 1'b0;
        release_reset();
    endtask

    initial begin
        rst_n      = 1'b1;
        alloc_req  = 1'b0;
        send_valid = 1'b0;
        send_vc    = '0;
        send_tail  = 1'b0;
        cred_valid = 1'b0;
        cred_vc    = '0;
        #2 rst_n = 1'b0;
        release_reset();
        check("reset", 1'b0, '0, '0, '0, 1'b0);

        // Allocation order, full occupancy, tail-with-credit retire, rr resume, drain.
        tbl.push_back(vec_t'{1, 0, 7'b0, 0, 0, 7'b0, 1, 7'b0000001, 7'b0000001, 7'b0000001, 0});
        tbl.push_back(vec_t'{1, 0, 7'b0, 0, 0, 7'b0, 1, 7'b0000010, 7'b0000011, 7'b0000011, 0});
        tbl.push_back(vec_t'{1, 0, 7'b0, 0, 0, 7'b0, 1, 7'b0000100, 7'b0000111, 7'b0000111, 0});
        tbl.push_back(vec_t'{1, 0, 7'b0, 0, 0, 7'b0, 1, 7'b0001000, 7'b0001111, 7'b0001111, 0});
        tbl.push_back(vec_t'{1, 0, 7'b0, 0, 0, 7'b0, 1, 7'b0010000, 7'b0011111, 7'b0011111, 0});
        tbl.push_back(vec_t'{1, 0, 7'b0, 0, 0, 7'b0, 1, 7'b0100000, 7'b0111111, 7'b0111111, 0});
        tbl.push_back(vec_t'{1, 0, 7'b0, 0, 0, 7'b0, 1, 7'b1000000, 7'b1111111, 7'b1111111, 0});
        tbl.push_back(vec_t'{1, 0, 7'b0, 0, 0, 7'b0, 0, 7'b0000000, 7'b1111111, 7'b1111111, 0});
        tbl.push_back(vec_t'{1, 1, 7'b0000100, 1, 1, 7'b0000100, 0, 7'b0, 7'b1111011, 7'b1111011, 0});
        tbl.push_back(vec_t'{1, 0, 7'b0, 0, 0, 7'b0, 1, 7'b0000100, 7'b1111111, 7'b1111111, 0});
        tbl.push_back(vec_t'{0, 1, 7'b0000001, 1, 1, 7'b0000001, 0, 7'b0, 7'b1111110, 7'b1111110, 0});
        tbl.push_back(vec_t'{0, 1, 7'b0001000, 1, 1, 7'b0001000, 0, 7'b0, 7'b1110110, 7'b1110110, 0});
        tbl.push_back(vec_t'{1, 0, 7'b0, 0, 0, 7'b0, 1, 7'b0001000, 7'b1111110, 7'b1111110, 0});
        tbl.push_back(vec_t'{1, 0, 7'b0, 0, 0, 7'b0, 1, 7'b0000001, 7'b1111111, 7'b1111111, 0});
        tbl.push_back(vec_t'{0, 1, 7'b0000001, 0, 0, 7'b0, 0, 7'b0, 7'b1111111, 7'b1111111, 0});
        tbl.push_back(vec_t'{0, 1, 7'b0000001, 0, 0, 7'b0, 0, 7'b0, 7'b1111111, 7'b1111111, 0});
        tbl.push_back(vec_t'{0, 1, 7'b0000001, 0, 0, 7'b0, 0, 7'b0, 7'b1111111, 7'b1111111, 0});
        tbl.push_back(vec_t'{0, 1, 7'b0000001, 1, 0, 7'b0, 0, 7'b0, 7'b1111111, 7'b1111110, 0});
        tbl.push_back(vec_t'{0, 0, 7'b0, 0, 1, 7'b0000001, 0, 7'b0, 7'b1111111, 7'b1111110, 0});
        tbl.push_back(vec_t'{0, 0, 7'b0, 0, 1, 7'b0000001, 0, 7'b0, 7'b1111111, 7'b1111110, 0});
        tbl.push_back(vec_t'{0, 0, 7'b0, 0, 1, 7'b0000001, 0, 7'b0, 7'b1111111, 7'b1111110, 0});
        tbl.push_back(vec_t'{0, 0, 7'b0, 0, 1, 7'b0000001, 0, 7'b0, 7'b1111110, 7'b1111110, 0});

        for (int i = 0; i < tbl.size(); i++) begin
            cyc(tbl[i].req, tbl[i].sv, tbl[i].svc, tbl[i].tail, tbl[i].cv, tbl[i].cvc);
            check($sformatf("vec%0d", i), tbl[i].gnt, tbl[i].vc, tbl[i].busy, tbl[i].cok,
                  tbl[i].err);
        end

        // VC1: bring counter to 2, then send+credit together must leave it at 2.
        cyc(0, 1, 7'b0000010, 0, 0, 7'b0);
        cyc(0, 1, 7'b0000010, 0, 0, 7'b0);
        check("vc1_cnt2", 0, '0, 7'b1111110, 7'b1111110, 0);
        cyc(0, 1, 7'b0000010, 0, 1, 7'b0000010);
        check("vc1_net0", 0, '0, 7'b1111110, 7'b1111110, 0);
        cyc(0, 1, 7'b0000010, 0, 0, 7'b0);
        check("vc1_cnt1", 0, '0, 7'b1111110, 7'b1111110, 0);
        cyc(0, 1, 7'b0000010, 0, 0, 7'b0);
        check("vc1_cnt0", 0, '0, 7'b1111110, 7'b1111100, 0);

        // Send on an idle VC5 raises a sticky error.
        cyc(0, 1, 7'b0100000, 1, 1, 7'b0100000);
        check("vc5_retire", 0, '0, 7'b1011110, 7'b1011100, 0);
        cyc(0, 1, 7'b0100000, 0, 0, 7'b0);
        check("err_send_idle", 0, '0, 7'b1011110, 7'b1011100, 1);
        repeat (3) cyc(0, 0, 7'b0, 0, 0, 7'b0);
        check("err_sticky", 0, '0, 7'b1011110, 7'b1011100, 1);

        // Non-one-hot send select is flagged and dropped.
        full_reset();
        check("reset2", 0, '0, '0, '0, 0);
        cyc(1, 0, 7'b0, 0, 0, 7'b0);
        cyc(1, 0, 7'b0, 0, 0, 7'b0);
        check("alloc01", 1, 7'b0000010, 7'b0000011, 7'b0000011, 0);
        cyc(0, 1, 7'b0000011, 0, 0, 7'b0);
        check("err_not_onehot", 0, '0, 7'b0000011, 7'b0000011, 1);
        repeat (3) cyc(0, 1, 7'b0000001, 0, 0, 7'b0);
        check("vc0_cnt1", 0, '0, 7'b0000011, 7'b0000011, 1);
        cyc(0, 1, 7'b0000001, 0, 0, 7'b0);
        check("vc0_cnt0", 0, '0, 7'b0000011, 7'b0000010, 1);

        // Credit on a full VC is flagged; error persists until reset.
        full_reset();
        check("reset3", 0, '0, '0, '0, 0);
        cyc(1, 0, 7'b0, 0, 0, 7'b0);
        check("alloc0", 1, 7'b0000001, 7'b0000001, 7'b0000001, 0);
        cyc(0, 0, 7'b0, 0, 1, 7'b0000001);
        check("err_cred_full", 0, '0, 7'b0000001, 7'b0000001, 1);
        repeat (2) cyc(0, 0, 7'b0, 0, 0, 7'b0);
        check("err_held", 0, '0, 7'b0000001, 7'b0000001, 1);
        rst_n = 1'b0;
        #1;
        check("err_cleared", 0, '0, '0, '0, 0);
        release_reset();

        // Reset in the middle of a drain discards VC3's partial credits.
        repeat (4) cyc(1, 0, 7'b0, 0, 0, 7'b0);
        check("alloc0to3", 1, 7'b0001000, 7'b0001111, 7'b0001111, 0);
        repeat (3) cyc(0, 1, 7'b0001000, 0, 0, 7'b0);
        cyc(0, 1, 7'b0001000, 1, 0, 7'b0);
        cyc(0, 0, 7'b0, 0, 1, 7'b0001000);
        check("vc3_drain1", 0, '0, 7'b0001111, 7'b0000111, 0);
        rst_n = 1'b0;
        #1;
        check("async_reset", 0, '0, '0, '0, 0);
        release_reset();
        check("post_reset", 0, '0, '0, '0, 0);
        cyc(1, 0, 7'b0, 0, 0, 7'b0);
        check("first_gnt_vc0", 1, 7'b0000001, 7'b0000001, 7'b0000001, 0);
        repeat (3) cyc(1, 0, 7'b0, 0, 0, 7'b0);
        check("regrant_vc3", 1, 7'b0001000, 7'b0001111, 7'b0001111, 0);
        repeat (3) cyc(0, 1, 7'b0001000, 0, 0, 7'b0);
        cyc(0, 1, 7'b0001000, 1, 0, 7'b0);
        check("vc3_full_credits", 0, '0, 7'b0001111, 7'b0000111, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
